// File: rtl/instr_sequencer.sv
// Control unit for the 4-bit nibble processor: decodes INSTR/OPRND into datapath
// strobes and keeps the carry/zero flags that feed the conditional jumps.
module instr_sequencer #(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic [3:0]        INSTR,
  input  logic [3:0]        OPRND,
  input  logic [7:0]        PROG_BYTE,
  input  logic              C,
  input  logic              ZERO,
  output logic              PC_INC,
  output logic              PC_LOAD,
  output logic [ADDR_W-1:0] PC_ADDR,
  output logic              FETCH_EN,
  output logic              OPER_EN,
  output logic              IN_EN,
  output logic              OUT_EN,
  output logic              ACC_EN,
  output logic [2:0]        ALU_SEL,
  output logic              CFLAG,
  output logic              ZFLAG,
  output logic              HALTED
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_JARG  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JNC   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [1:0] state_q, state_d;
  logic       cflag_q, cflag_d;
  logic       zflag_q, zflag_d;
  logic       jump_taken;

  // Every strobe defaults low so reset, ENABLE=0 and HALT all fall out of one path.
  always_comb begin
    state_d    = state_q;
    cflag_d    = cflag_q;
    zflag_d    = zflag_q;
    jump_taken = 1'b0;
    PC_INC     = 1'b0;
    PC_LOAD    = 1'b0;
    PC_ADDR    = '0;
    FETCH_EN   = 1'b0;
    OPER_EN    = 1'b0;
    IN_EN      = 1'b0;
    OUT_EN     = 1'b0;
    ACC_EN     = 1'b0;
    ALU_SEL    = 3'b000;

    if (RST && ENABLE) begin
      case (state_q)
        ST_FETCH: begin
          FETCH_EN = 1'b1;
          PC_INC   = 1'b1;
          state_d  = ST_EXEC;
        end

        ST_EXEC: begin
          state_d = ST_FETCH;
          case (INSTR)
            OP_LIT: begin
              OPER_EN = 1'b1;
              ACC_EN  = 1'b1;
            end
            OP_ADDI: begin
              OPER_EN = 1'b1;
              ALU_SEL = 3'b011;
              ACC_EN  = 1'b1;
              cflag_d = C;
              zflag_d = ZERO;
            end
            OP_SUBI: begin
              OPER_EN = 1'b1;
              ALU_SEL = 3'b001;
              ACC_EN  = 1'b1;
              cflag_d = C;
              zflag_d = ZERO;
            end
            OP_NANDI: begin
              OPER_EN = 1'b1;
              ALU_SEL = 3'b100;
              ACC_EN  = 1'b1;
            end
            OP_CMPI: begin
              OPER_EN = 1'b1;
              ALU_SEL = 3'b001;
              cflag_d = C;
              zflag_d = ZERO;
            end
            OP_OUT: begin
              ALU_SEL = 3'b010;
              OUT_EN  = 1'b1;
            end
            OP_IN: begin
              IN_EN  = 1'b1;
              ACC_EN = 1'b1;
            end
            OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: state_d = ST_JARG;
            OP_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end

        // INSTR/OPRND are still held by the fetch register; PROG_BYTE is the low byte.
        ST_JARG: begin
          case (INSTR)
            OP_JMP:  jump_taken = 1'b1;
            OP_JC:   jump_taken = cflag_q;
            OP_JNC:  jump_taken = ~cflag_q;
            OP_JZ:   jump_taken = zflag_q;
            OP_JNZ:  jump_taken = ~zflag_q;
            default: jump_taken = 1'b0;
          endcase
          if (jump_taken) begin
            PC_LOAD = 1'b1;
            PC_ADDR = ADDR_W'({OPRND, PROG_BYTE});
          end else begin
            PC_INC = 1'b1;
          end
          state_d = ST_FETCH;
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_FETCH;
      cflag_q <= 1'b0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cflag_q <= cflag_d;
      zflag_q <= zflag_d;
    end
  end

  assign CFLAG  = cflag_q;
  assign ZFLAG  = zflag_q;
  assign HALTED = RST && (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed program fragments followed by
// randomized instruction streams, all compared against an instruction-level model.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [7:0]  pb;
  logic        c_in;
  logic        z_in;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_addr;
  logic        fetch_en;
  logic        oper_en;
  logic        in_en;
  logic        out_en;
  logic        acc_en;
  logic [2:0]  alu_sel;
  logic        cflag;
  logic        zflag;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Model: which part of an instruction we are in (0 opcode fetch, 1 execute,
  // 2 jump argument), whether the core has halted, and the two flags.
  int   m_phase  = 0;
  logic m_halted = 1'b0;
  logic m_cf     = 1'b0;
  logic m_zf     = 1'b0;

  logic [2:0] alu_tab [8] = '{3'd0, 3'd0, 3'd3, 3'd1, 3'd4, 3'd1, 3'd2, 3'd0};

  instr_sequencer #(.ADDR_W(12)) dut (
    .CLK(clk), .RST(rst), .ENABLE(en), .INSTR(instr), .OPRND(oprnd),
    .PROG_BYTE(pb), .C(c_in), .ZERO(z_in),
    .PC_INC(pc_inc), .PC_LOAD(pc_load), .PC_ADDR(pc_addr), .FETCH_EN(fetch_en),
    .OPER_EN(oper_en), .IN_EN(in_en), .OUT_EN(out_en), .ACC_EN(acc_en),
    .ALU_SEL(alu_sel), .CFLAG(cflag), .ZFLAG(zflag), .HALTED(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bundle order: pc_inc, pc_load, pc_addr, fetch_en, oper_en, in_en, out_en, acc_en, alu_sel, halted
  function automatic logic [22:0] expected_outputs();
    int   op;
    logic take;
    logic e_inc, e_load, e_fetch, e_oper, e_in, e_out, e_acc;
    logic [11:0] e_addr;
    logic [2:0]  e_sel;
    op = int'(instr);
    {e_inc, e_load, e_fetch, e_oper, e_in, e_out, e_acc} = '0;
    e_addr = '0;
    e_sel  = '0;
    if (rst && en && !m_halted) begin
      if (m_phase == 0) begin
        e_fetch = 1'b1;
        e_inc   = 1'b1;
      end else if (m_phase == 1) begin
        e_oper = (op >= 1 && op <= 5);
        e_in   = (op == 7);
        e_out  = (op == 6);
        e_acc  = (op >= 1 && op <= 4) || op == 7;
        if (op < 8) e_sel = alu_tab[op];
      end else begin
        case (op)
          8:       take = 1'b1;
          9:       take = m_cf;
          10:      take = !m_cf;
          11:      take = m_zf;
          default: take = !m_zf;
        endcase
        if (take) begin
          e_load = 1'b1;
          e_addr = {oprnd, pb};
        end else begin
          e_inc = 1'b1;
        end
      end
    end
    return {e_inc, e_load, e_addr, e_fetch, e_oper, e_in, e_out, e_acc, e_sel, rst && m_halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] i, input logic [3:0] o,
                       input logic [7:0] p, input logic cc, input logic zz);
    rst   = r;
    en    = e;
    instr = i;
    oprnd = o;
    pb    = p;
    c_in  = cc;
    z_in  = zz;
  endtask

  task automatic check_output(input string tag);
    logic [22:0] obs;
    @(negedge clk);
    obs = {pc_inc, pc_load, pc_addr, fetch_en, oper_en, in_en, out_en, acc_en, alu_sel, halted};
    check({tag, "_strobes"}, 32'(obs), 32'(expected_outputs()));
    check({tag, "_flags"}, 32'({cflag, zflag}), 32'({m_cf, m_zf}));
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int op;
    @(posedge clk);
    op = int'(instr);
    if (!rst) begin
      m_phase  = 0;
      m_halted = 1'b0;
      m_cf     = 1'b0;
      m_zf     = 1'b0;
    end else if (en && !m_halted) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (op == 2 || op == 3 || op == 5) {m_cf, m_zf} = {c_in, z_in};
        if (op == 15) m_halted = 1'b1;
        else if (op >= 8 && op <= 12) m_phase = 2;
        else m_phase = 0;
      end else begin
        m_phase = 0;
      end
    end
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_output("reset");
      tick();
    end
    check({"reset_halted"}, 32'(halted), 32'(0));

    // LIT 5; ADDI C with the ALU reporting carry and zero
    drive(1'b1, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    check_output("first_fetch");
    check("first_fetch_en", 32'({fetch_en, pc_inc}), 32'(2'b11));
    tick();
    drive(1'b1, 1'b1, 4'h1, 4'h5, 8'h00, 1'b0, 1'b0);
    check_output("lit");
    check("lit_acc_sel", 32'({acc_en, alu_sel}), 32'(4'b1000));
    tick();
    drive(1'b1, 1'b1, 4'h1, 4'h5, 8'h00, 1'b0, 1'b0);
    check_output("fetch_addi");
    tick();
    drive(1'b1, 1'b1, 4'h2, 4'hC, 8'h00, 1'b1, 1'b1);
    check_output("addi");
    check("addi_acc_sel", 32'({acc_en, alu_sel}), 32'(4'b1011));
    tick();

    // CMPI 3 with ZERO=1, then JZ to 0x140
    drive(1'b1, 1'b1, 4'h2, 4'hC, 8'h00, 1'b0, 1'b0);
    check_output("fetch_cmpi");
    check("addi_flags", 32'({cflag, zflag}), 32'(2'b11));
    tick();
    drive(1'b1, 1'b1, 4'h5, 4'h3, 8'h00, 1'b0, 1'b1);
    check_output("cmpi");
    check("cmpi_no_acc", 32'(acc_en), 32'(0));
    tick();
    drive(1'b1, 1'b1, 4'h5, 4'h3, 8'h00, 1'b0, 1'b0);
    check_output("fetch_jz");
    tick();
    drive(1'b1, 1'b1, 4'hB, 4'h1, 8'h00, 1'b0, 1'b0);
    check_output("jz_exec");
    tick();
    drive(1'b1, 1'b1, 4'hB, 4'h1, 8'h40, 1'b0, 1'b0);
    check_output("jz_arg");
    check("jz_load_addr", 32'({pc_load, pc_inc, pc_addr}), 32'({2'b10, 12'h140}));
    tick();

    // JNZ with ZFLAG=1 falls through and skips the second byte
    drive(1'b1, 1'b1, 4'hB, 4'h1, 8'h00, 1'b0, 1'b0);
    check_output("fetch_jnz");
    tick();
    drive(1'b1, 1'b1, 4'hC, 4'h2, 8'h00, 1'b0, 1'b0);
    check_output("jnz_exec");
    tick();
    drive(1'b1, 1'b1, 4'hC, 4'h2, 8'h10, 1'b0, 1'b0);
    check_output("jnz_arg");
    check("jnz_skip", 32'({pc_load, pc_inc, pc_addr}), 32'({2'b01, 12'h000}));
    tick();

    // JMP stalled by ENABLE=0 while the argument byte is pending
    drive(1'b1, 1'b1, 4'hC, 4'h2, 8'h00, 1'b0, 1'b0);
    check_output("fetch_jmp");
    tick();
    drive(1'b1, 1'b1, 4'h8, 4'hA, 8'h00, 1'b0, 1'b0);
    check_output("jmp_exec");
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'h8, 4'hA, 8'h5A, 1'b1, 1'b1);
      check_output("jmp_stall");
      check("jmp_stall_quiet", 32'({pc_load, pc_inc, pc_addr}), 32'(0));
      tick();
    end
    drive(1'b1, 1'b1, 4'h8, 4'hA, 8'h5A, 1'b0, 1'b0);
    check_output("jmp_arg");
    check("jmp_resume", 32'({pc_load, pc_addr}), 32'({1'b1, 12'hA5A}));
    tick();

    // Random instruction stream with occasional stalls and resets
    for (int k = 0; k < 400; k++) begin
      if (m_phase == 0) begin
        instr = 4'($urandom_range(0, 14));
        oprnd = 4'($urandom);
      end
      rst  = ($urandom_range(0, 49) != 0);
      en   = ($urandom_range(0, 4) != 0);
      pb   = 8'($urandom);
      c_in = 1'($urandom);
      z_in = 1'($urandom);
      check_output("random");
      tick();
    end

    // HALT holds until reset
    drive(1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    check_output("pre_halt_reset");
    tick();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    check_output("fetch_halt");
    tick();
    drive(1'b1, 1'b1, 4'hF, 4'h0, 8'h00, 1'b0, 1'b0);
    check_output("halt_exec");
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 4'h1, 4'h0, 8'hFF, 1'b1, 1'b1);
      check_output("halted");
      check("halted_flag", 32'({halted, fetch_en, pc_inc, acc_en}), 32'(4'b1000));
      tick();
    end
    drive(1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    check_output("halt_reset");
    tick();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    check_output("after_halt");
    check("after_halt_fetch", 32'({halted, fetch_en}), 32'(2'b01));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
